// File: rtl/bal_pkg.sv
// Shared types, constants and helpers for the balance controller.
package bal_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RAMP  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // Steering pot is clipped to [STEER_MIN, STEER_MAX] and centred on STEER_MID
    localparam logic [11:0] STEER_MIN = 12'h200;
    localparam logic [11:0] STEER_MAX = 12'hE00;
    localparam logic [11:0] STEER_MID = 12'h800;

    // PID term widths and gains
    localparam int P_COEFF = 5;
    localparam int INTEG_W = 18;
    localparam int EP_W    = 10;
    localparam int I_W     = 15;
    localparam int D_W     = 13;
    localparam int PID_W   = 16;

    // Clamp a signed value into the two's-complement range of a w-bit signed number
    function automatic logic signed [31:0] sat_s(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/bal_pid.sv
// PID core: captures a pitch sample on vld, maintains a saturating integrator
// and presents the combined P+I+D term one cycle later with pid_vld.
module bal_pid
    import bal_pkg::*;
#(
    parameter int PTCH_W   = 16,
    parameter int FAST_SIM = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vld,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [PTCH_W-1:0] ptch,
    input  logic signed [PTCH_W-1:0] ptch_rt,
    output logic signed [PID_W-1:0]  pid,
    output logic                     pid_vld
);

    localparam int I_SHIFT = (FAST_SIM != 0) ? 1 : 6;
    // Integrator limit is symmetric: +/-(2^17 - 1)
    localparam logic signed [31:0] INTEG_MAX = (32'sd1 <<< (INTEG_W - 1)) - 32'sd1;

    logic signed [EP_W-1:0]    ep_in;
    logic signed [EP_W-1:0]    ep_q;
    logic signed [PTCH_W-1:0]  rt_q;
    logic signed [INTEG_W-1:0] integ;
    logic signed [INTEG_W-1:0] integ_nxt;
    logic signed [31:0]        integ_sum;
    logic signed [31:0]        p_term;
    logic signed [31:0]        i_term;
    logic signed [31:0]        d_term;
    logic                      v_q;

    // Error saturation and saturating integrator accumulate
    always_comb begin
        ep_in     = EP_W'(sat_s(32'(ptch), EP_W));
        integ_sum = 32'(integ) + 32'(ep_in);
        if (integ_sum > INTEG_MAX) begin
            integ_nxt = INTEG_W'(INTEG_MAX);
        end else if (integ_sum < -INTEG_MAX) begin
            integ_nxt = INTEG_W'(-INTEG_MAX);
        end else begin
            integ_nxt = INTEG_W'(integ_sum);
        end
    end

    // Sample capture and integrator state; clear wins over accumulate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ep_q  <= '0;
            rt_q  <= '0;
            integ <= '0;
            v_q   <= 1'b0;
        end else begin
            v_q <= vld;
            if (vld) begin
                ep_q <= ep_in;
                rt_q <= ptch_rt;
            end
            if (clr) begin
                integ <= '0;
            end else if (vld && en) begin
                integ <= integ_nxt;
            end
        end
    end

    // P, I and D terms from the captured sample and the updated integrator
    always_comb begin
        p_term  = 32'(ep_q) * P_COEFF;
        i_term  = sat_s(32'(integ) >>> I_SHIFT, I_W);
        d_term  = sat_s(-(32'(rt_q) >>> 6), D_W);
        pid     = PID_W'(sat_s(p_term + i_term + d_term, PID_W));
        pid_vld = v_q;
    end

endmodule

// File: rtl/bal_ctrl_gen2.sv
// Balance controller top: power/ramp/run/fault sequencing, soft-start
// scaling, steering mix and the over-speed supervisor around bal_pid.
//
// Handshake: vld is a one-cycle strobe with no back-pressure; every vld
// accepted at edge N yields exactly one spd_vld strobe at edge N+1, whose
// lft_spd/rght_spd/too_fast belong to that sample. vld may be high on
// consecutive cycles.
module bal_ctrl_gen2
    import bal_pkg::*;
#(
    parameter int PTCH_W      = 16,
    parameter int SPD_W       = 12,
    parameter int SS_W        = 8,
    parameter int FAST_SIM    = 1,
    parameter int FAST_THRESH = 1536,
    parameter int TF_CNT      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vld,
    input  logic signed [PTCH_W-1:0] ptch,
    input  logic signed [PTCH_W-1:0] ptch_rt,
    input  logic                     pwr_up,
    input  logic                     rider_off,
    input  logic                     en_steer,
    input  logic [11:0]              steer_pot,
    output logic signed [SPD_W-1:0]  lft_spd,
    output logic signed [SPD_W-1:0]  rght_spd,
    output logic                     spd_vld,
    output logic                     too_fast,
    output logic                     fault,
    output logic [SS_W-1:0]          ss_tmr,
    output state_t                   dbg_state
);

    localparam int PRESC_W = 8;
    localparam logic [PRESC_W-1:0] PRESC_MAX = (FAST_SIM != 0) ? 8'h00 : 8'hFF;
    localparam logic [SS_W-1:0] SS_MAX = '1;
    localparam logic [SS_W-1:0] SS_PRE = {{(SS_W-1){1'b1}}, 1'b0};
    localparam int CNT_W = $clog2(TF_CNT + 1);
    localparam logic [CNT_W-1:0] TRIP_AT = CNT_W'(TF_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TF_CNT);

    state_t               state;
    state_t               state_nxt;
    logic                 ss_clr;
    logic                 ss_inc;
    logic                 integ_clr;
    logic                 integ_en;
    logic                 out_kill;
    logic                 trip;
    logic                 tick;
    logic [PRESC_W-1:0]   presc;
    logic [CNT_W-1:0]     tf_cnt;

    logic signed [PID_W-1:0] pid;
    logic                    pid_vld;

    logic [11:0]        pot_c;
    logic signed [31:0] steer_in;
    logic signed [15:0] steer_q;
    logic signed [31:0] scaled;
    logic signed [31:0] lft_full;
    logic signed [31:0] rght_full;
    logic               tf_raw;
    logic               tf_nxt;

    bal_pid #(
        .PTCH_W   (PTCH_W),
        .FAST_SIM (FAST_SIM)
    ) u_pid (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld     (vld),
        .clr     (integ_clr),
        .en      (integ_en),
        .ptch    (ptch),
        .ptch_rt (ptch_rt),
        .pid     (pid),
        .pid_vld (pid_vld)
    );

    assign tick      = (presc == PRESC_MAX);
    assign out_kill  = (state == ST_OFF) || (state == ST_FAULT);
    assign fault     = (state == ST_FAULT);
    assign dbg_state = state;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_OFF;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-state controls; pwr_up low overrides everything
    always_comb begin
        state_nxt = state;
        ss_clr    = 1'b0;
        ss_inc    = 1'b0;
        integ_clr = 1'b0;
        integ_en  = 1'b0;
        if (!pwr_up) begin
            state_nxt = ST_OFF;
            ss_clr    = 1'b1;
            integ_clr = 1'b1;
        end else begin
            case (state)
                ST_OFF: begin
                    ss_clr    = 1'b1;
                    integ_clr = 1'b1;
                    state_nxt = ST_RAMP;
                end
                ST_RAMP, ST_RUN: begin
                    if (trip) begin
                        state_nxt = ST_FAULT;
                        integ_clr = 1'b1;
                    end else if (rider_off) begin
                        state_nxt = ST_RAMP;
                        ss_clr    = 1'b1;
                        integ_clr = 1'b1;
                    end else begin
                        integ_en = 1'b1;
                        if (state == ST_RAMP) begin
                            if (ss_tmr == SS_MAX) begin
                                state_nxt = ST_RUN;
                            end else if (tick) begin
                                ss_inc = 1'b1;
                                if (ss_tmr == SS_PRE) begin
                                    state_nxt = ST_RUN;
                                end
                            end
                        end
                    end
                end
                ST_FAULT: begin
                    integ_clr = 1'b1;
                end
                default: begin
                    state_nxt = ST_OFF;
                end
            endcase
        end
    end

    // Soft-start timer and its ramp prescaler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_tmr <= '0;
            presc  <= '0;
        end else if (ss_clr) begin
            ss_tmr <= '0;
            presc  <= '0;
        end else begin
            if (ss_inc) begin
                ss_tmr <= ss_tmr + SS_W'(1);
            end
            if (state == ST_RAMP) begin
                presc <= tick ? '0 : presc + PRESC_W'(1);
            end else begin
                presc <= '0;
            end
        end
    end

    // Steering term from the clipped pot, evaluated at sample capture
    always_comb begin
        if (steer_pot < STEER_MIN) begin
            pot_c = STEER_MIN;
        end else if (steer_pot > STEER_MAX) begin
            pot_c = STEER_MAX;
        end else begin
            pot_c = steer_pot;
        end
        if (en_steer) begin
            steer_in = (($signed(32'(pot_c)) - $signed(32'(STEER_MID))) * 32'sd3) >>> 4;
        end else begin
            steer_in = 32'sd0;
        end
    end

    // Steer term is captured alongside the pitch sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            steer_q <= '0;
        end else if (vld) begin
            steer_q <= 16'(steer_in);
        end
    end

    // Soft-start scaling, steer mix, output saturation and over-speed detect
    always_comb begin
        scaled    = (32'(pid) * $signed(32'(ss_tmr))) >>> SS_W;
        lft_full  = sat_s(scaled + 32'(steer_q), SPD_W);
        rght_full = sat_s(scaled - 32'(steer_q), SPD_W);
        tf_raw    = (lft_full > FAST_THRESH) || (lft_full < -FAST_THRESH) ||
                    (rght_full > FAST_THRESH) || (rght_full < -FAST_THRESH);
        tf_nxt    = pid_vld && !out_kill && tf_raw;
        trip      = tf_nxt && (tf_cnt == TRIP_AT);
    end

    // Registered speed outputs; OFF and FAULT still strobe but with zero speeds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_spd  <= '0;
            rght_spd <= '0;
            spd_vld  <= 1'b0;
            too_fast <= 1'b0;
        end else if (pid_vld) begin
            spd_vld <= 1'b1;
            if (out_kill) begin
                lft_spd  <= '0;
                rght_spd <= '0;
                too_fast <= 1'b0;
            end else begin
                lft_spd  <= SPD_W'(lft_full);
                rght_spd <= SPD_W'(rght_full);
                too_fast <= tf_raw;
            end
        end else begin
            spd_vld <= 1'b0;
        end
    end

    // Consecutive over-speed sample counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tf_cnt <= '0;
        end else if (!pwr_up || (state == ST_OFF)) begin
            tf_cnt <= '0;
        end else if (pid_vld) begin
            if (tf_nxt) begin
                tf_cnt <= (tf_cnt == CNT_TOP) ? tf_cnt : tf_cnt + CNT_W'(1);
            end else begin
                tf_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bal_ctrl_gen2.sv
// Directed bench for bal_ctrl_gen2 with a scoreboard on the spd_vld stream.
module tb_bal_ctrl_gen2;
    import bal_pkg::*;

    localparam int SPD_W = 12;
    localparam int EXP_W = 2 + 2 * SPD_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               vld = 1'b0;
    logic signed [15:0] ptch = '0;
    logic signed [15:0] ptch_rt = '0;
    logic               pwr_up = 1'b0;
    logic               rider_off = 1'b0;
    logic               en_steer = 1'b0;
    logic [11:0]        steer_pot = 12'h800;

    logic signed [SPD_W-1:0] lft_spd, rght_spd;
    logic                    spd_vld, too_fast, fault;
    logic [7:0]              ss_tmr;
    state_t                  dbg_state;

    logic signed [SPD_W-1:0] lft_spd_s, rght_spd_s;
    logic                    spd_vld_s, too_fast_s, fault_s;
    logic [7:0]              ss_tmr_s;
    state_t                  dbg_state_s;

    int checks = 0;
    int errors = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] mon_got;
    logic [EXP_W-1:0] mon_exp;

    bal_ctrl_gen2 u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vld       (vld),
        .ptch      (ptch),
        .ptch_rt   (ptch_rt),
        .pwr_up    (pwr_up),
        .rider_off (rider_off),
        .en_steer  (en_steer),
        .steer_pot (steer_pot),
        .lft_spd   (lft_spd),
        .rght_spd  (rght_spd),
        .spd_vld   (spd_vld),
        .too_fast  (too_fast),
        .fault     (fault),
        .ss_tmr    (ss_tmr),
        .dbg_state (dbg_state)
    );

    // Second instance whose threshold can never be exceeded, so its
    // integrator can be driven all the way into saturation.
    bal_ctrl_gen2 #(.FAST_THRESH(2047)) u_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .vld       (vld),
        .ptch      (ptch),
        .ptch_rt   (ptch_rt),
        .pwr_up    (pwr_up),
        .rider_off (rider_off),
        .en_steer  (en_steer),
        .steer_pot (steer_pot),
        .lft_spd   (lft_spd_s),
        .rght_spd  (rght_spd_s),
        .spd_vld   (spd_vld_s),
        .too_fast  (too_fast_s),
        .fault     (fault_s),
        .ss_tmr    (ss_tmr_s),
        .dbg_state (dbg_state_s)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [EXP_W-1:0] pk(input logic f, input logic tf, input int l, input int r);
        return {f, tf, SPD_W'(l), SPD_W'(r)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Driver: one vld strobe, expected response queued for the monitor
    task automatic pulse(input logic signed [15:0] p, input logic signed [15:0] r,
                         input logic [EXP_W-1:0] e);
        ptch    = p;
        ptch_rt = r;
        vld     = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        vld = 1'b0;
    endtask

    // Monitor: every spd_vld strobe is popped against the expected queue
    always @(negedge clk) begin
        if (rst_n && spd_vld) begin
            checks++;
            mon_got = {fault, too_fast, lft_spd, rght_spd};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spd_unexpected: got lft=%0d rght=%0d with nothing expected", lft_spd, rght_spd);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL spd_sample: got fault=%0b too_fast=%0b lft=%0d rght=%0d expected fault=%0b too_fast=%0b lft=%0d rght=%0d",
                             mon_got[EXP_W-1], mon_got[EXP_W-2],
                             $signed(mon_got[2*SPD_W-1:SPD_W]), $signed(mon_got[SPD_W-1:0]),
                             mon_exp[EXP_W-1], mon_exp[EXP_W-2],
                             $signed(mon_exp[2*SPD_W-1:SPD_W]), $signed(mon_exp[SPD_W-1:0]));
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        // Reset values
        wait_cyc(2);
        check("rst_lft", 32'(lft_spd), 32'sd0);
        check("rst_rght", 32'(rght_spd), 32'sd0);
        check("rst_spd_vld", 32'(spd_vld), 32'd0);
        check("rst_too_fast", 32'(too_fast), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_ss_tmr", 32'(ss_tmr), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_OFF));
        rst_n = 1'b1;
        wait_cyc(1);

        // OFF: vld still strobes spd_vld, speeds zero, integrator untouched
        pulse(16'sd100, 16'sd0, pk(1'b0, 1'b0, 0, 0));
        wait_cyc(2);
        check("off_state", 32'(dbg_state), 32'(ST_OFF));
        check("off_integ", 32'(u_dut.u_pid.integ), 32'sd0);

        // Soft-start ramp 0..255, one step per clock
        pwr_up = 1'b1;
        @(negedge clk);
        check("ramp_enter_state", 32'(dbg_state), 32'(ST_RAMP));
        check("ramp_enter_ss", 32'(ss_tmr), 32'd0);
        for (int i = 1; i <= 255; i++) begin
            @(negedge clk);
            check("ramp_ss", 32'(ss_tmr), 32'(i));
        end
        check("ramp_done_state", 32'(dbg_state), 32'(ST_RUN));
        wait_cyc(3);
        check("run_ss_hold", 32'(ss_tmr), 32'd255);
        check("run_state_hold", 32'(dbg_state), 32'(ST_RUN));

        // Single sample: P=500, I=50, D=0, PID=550, scaled 547
        en_steer = 1'b0;
        pulse(16'sd100, 16'sd0, pk(1'b0, 1'b0, 547, 547));
        check("pid_integ_100", 32'(u_dut.u_pid.integ), 32'sd100);
        wait_cyc(2);

        // rider_off clears integrator and ramp, ramp restarts on release
        rider_off = 1'b1;
        wait_cyc(2);
        check("rider_state", 32'(dbg_state), 32'(ST_RAMP));
        check("rider_ss", 32'(ss_tmr), 32'd0);
        check("rider_integ", 32'(u_dut.u_pid.integ), 32'sd0);
        rider_off = 1'b0;
        @(negedge clk);
        check("rider_restart_ss", 32'(ss_tmr), 32'd1);
        for (int i = 0; i < 300 && dbg_state != ST_RUN; i++) @(negedge clk);
        check("rerun_state", 32'(dbg_state), 32'(ST_RUN));
        check("rerun_ss", 32'(ss_tmr), 32'd255);

        // Steer mix and D term, back-to-back samples with PID from ptch=0
        en_steer  = 1'b1;
        steer_pot = 12'hFFF;
        pulse(16'sd0, 16'sd0, pk(1'b0, 1'b0, 288, -288));
        steer_pot = 12'h000;
        pulse(16'sd0, 16'sd0, pk(1'b0, 1'b0, -288, 288));
        steer_pot = 12'h900;
        pulse(16'sd0, 16'sd0, pk(1'b0, 1'b0, 48, -48));
        en_steer  = 1'b0;
        steer_pot = 12'hFFF;
        pulse(16'sd0, 16'sd0, pk(1'b0, 1'b0, 0, 0));
        pulse(16'sd0, 16'sd640, pk(1'b0, 1'b0, -10, -10));
        pulse(16'sd0, -16'sd640, pk(1'b0, 1'b0, 9, 9));
        wait_cyc(3);

        // Over-speed: saturated outputs, FAULT on the 4th sample, zero afterwards
        for (int k = 1; k <= 300; k++) begin
            if (k <= 3) begin
                pulse(16'sh7FFF, 16'sd0, pk(1'b0, 1'b1, 2047, 2047));
            end else if (k == 4) begin
                pulse(16'sh7FFF, 16'sd0, pk(1'b1, 1'b1, 2047, 2047));
            end else begin
                pulse(16'sh7FFF, 16'sd0, pk(1'b1, 1'b0, 0, 0));
            end
            if (k == 256) check("sat_integ_256", 32'(u_sat.u_pid.integ), 32'sd130816);
            if (k == 257) check("sat_integ_257", 32'(u_sat.u_pid.integ), 32'sd131071);
            if (k == 300) check("sat_integ_300", 32'(u_sat.u_pid.integ), 32'sd131071);
        end
        wait_cyc(2);
        check("sat_lft", 32'(lft_spd_s), 32'sd2047);
        check("sat_rght", 32'(rght_spd_s), 32'sd2047);
        check("sat_too_fast", 32'(too_fast_s), 32'd0);
        check("sat_fault", 32'(fault_s), 32'd0);
        check("fault_flag", 32'(fault), 32'd1);
        check("fault_state", 32'(dbg_state), 32'(ST_FAULT));
        check("fault_integ", 32'(u_dut.u_pid.integ), 32'sd0);
        check("fault_too_fast", 32'(too_fast), 32'd0);

        // Recovery: pwr_up low for one cycle -> OFF -> RAMP
        pwr_up = 1'b0;
        @(negedge clk);
        check("rec_off_state", 32'(dbg_state), 32'(ST_OFF));
        check("rec_off_fault", 32'(fault), 32'd0);
        check("rec_off_ss", 32'(ss_tmr), 32'd0);
        check("rec_off_cnt", 32'(u_dut.tf_cnt), 32'd0);
        pwr_up = 1'b1;
        @(negedge clk);
        check("rec_ramp_state", 32'(dbg_state), 32'(ST_RAMP));
        check("rec_ramp_fault", 32'(fault), 32'd0);
        check("rec_ramp_cnt", 32'(u_dut.tf_cnt), 32'd0);
        pulse(16'sd0, 16'sd0, pk(1'b0, 1'b0, 0, 0));
        wait_cyc(3);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
